// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308-style ADC responder.
package adc_pkg;

  localparam int CFG_W = 6;
  localparam int RES_W = 12;

  // Bit positions inside the 6-bit config word {S/D,O/S,S1,S0,UNI,SLP}
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CONVERT = 2'd2
  } state_t;

  function automatic logic [2:0] cfg_channel(input logic [CFG_W-1:0] cfg);
    return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
  endfunction

endpackage

// File: rtl/adc_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus rise/fall strobes
// taken from the second and third stages.
module adc_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      sync_p2 <= RST_VAL;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;
  assign fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/adc_ltc2308_responder.sv
// Device end of the 4-wire ADC link: emulates an 8-channel 12-bit converter whose
// frames return the conversion selected by the previous frame's config word.
module adc_ltc2308_responder
  import adc_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int DATA_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_sclk,
  input  logic              adc_cs_n,
  input  logic              adc_din,
  output logic              adc_dout,
  input  logic              ch_wr_en,
  input  logic [2:0]        ch_wr_addr,
  input  logic [DATA_W-1:0] ch_wr_data,
  output logic              cfg_valid,
  output logic [CFG_W-1:0]  cfg_word,
  output logic              busy,
  output logic              frame_err,
  input  logic              err_clr
);

  if (DATA_W != RES_W) begin : g_bad_data_w
    $error("adc_ltc2308_responder: DATA_W must be 12");
  end
  if (CONV_CYCLES < 1 || CONV_CYCLES > 255) begin : g_bad_conv_cycles
    $error("adc_ltc2308_responder: CONV_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

  // Bipolar channels report offset-binary samples as two's complement.
  function automatic logic [DATA_W-1:0] to_result(input logic [DATA_W-1:0] v,
                                                  input logic uni);
    return uni ? v : (v ^ {1'b1, {(DATA_W-1){1'b0}}});
  endfunction

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic din_p0, din_p1;

  adc_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .reset    (reset),
    .async_in (adc_sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  adc_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk      (clk),
    .reset    (reset),
    .async_in (adc_cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // din sits at the same sync depth as the sclk stage used for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
    end else begin
      din_p0 <= adc_din;
      din_p1 <= din_p0;
    end
  end

  logic [DATA_W-1:0] bank [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else if (ch_wr_en) begin
      bank[ch_wr_addr] <= ch_wr_data;
    end
  end

  logic [2:0]        conv_ch;
  logic [DATA_W-1:0] conv_v;

  // A write landing on the captured channel in the capture cycle wins.
  assign conv_ch = cfg_channel(cfg_word);
  assign conv_v  = (ch_wr_en && ch_wr_addr == conv_ch) ? ch_wr_data : bank[conv_ch];

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [CFG_W-1:0]  cfg_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] result;
  logic [7:0]        cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cfg_sr    <= '0;
      tx_sr     <= '0;
      result    <= '0;
      cnt       <= '0;
      adc_dout  <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_word  <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;

      if (state == CONVERT && cs_fall) frame_err <= 1'b1;
      else if (err_clr)                frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            cfg_sr   <= '0;
            tx_sr    <= result;
            adc_dout <= result[DATA_W-1];
          end else begin
            adc_dout <= 1'b0;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            adc_dout <= 1'b0;
            if (bit_cnt >= 4'd6) begin
              cfg_word  <= cfg_sr;
              cfg_valid <= 1'b1;
              cnt       <= CONV_LOAD;
              busy      <= 1'b1;
              state     <= CONVERT;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (sclk_rise) begin
              if (bit_cnt < 4'd6) cfg_sr <= {cfg_sr[CFG_W-2:0], din_p1};
              if (bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
            end
            // Zero fill makes the line go quiet once all 12 bits are out
            if (sclk_fall) begin
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
              adc_dout <= tx_sr[DATA_W-2];
            end
          end
        end

        CONVERT: begin
          adc_dout <= 1'b0;
          if (cnt == 8'd0) begin
            result <= to_result(conv_v, cfg_word[CFG_UNI]);
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          adc_dout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ltc2308_responder.sv
// Bench for adc_ltc2308_responder: drives controller-side frames at clk/8 and
// compares serial results against a behavioural converter model.
module tb_adc_ltc2308_responder;

  localparam int CONV = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        adc_sclk = 1'b0;
  logic        adc_cs_n = 1'b1;
  logic        adc_din = 1'b0;
  logic        adc_dout;
  logic        ch_wr_en = 1'b0;
  logic [2:0]  ch_wr_addr = '0;
  logic [11:0] ch_wr_data = '0;
  logic        cfg_valid;
  logic [5:0]  cfg_word;
  logic        busy;
  logic        frame_err;
  logic        err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_cfg_valid = 0;

  logic [11:0] m_bank [8];
  logic [11:0] m_result;

  adc_ltc2308_responder #(.CONV_CYCLES(CONV), .DATA_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_sclk   (adc_sclk),
    .adc_cs_n   (adc_cs_n),
    .adc_din    (adc_din),
    .adc_dout   (adc_dout),
    .ch_wr_en   (ch_wr_en),
    .ch_wr_addr (ch_wr_addr),
    .ch_wr_data (ch_wr_data),
    .cfg_valid  (cfg_valid),
    .cfg_word   (cfg_word),
    .busy       (busy),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_valid === 1'b1) n_cfg_valid++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  // Converter model: channel index from S1,S0,O/S; bipolar reads as sample minus mid-scale.
  function automatic logic [11:0] model_conv(input logic [5:0] cfg);
    int ch;
    ch = int'(cfg[3]) * 4 + int'(cfg[2]) * 2 + int'(cfg[4]);
    if (cfg[1]) return m_bank[ch];
    return 12'(int'(m_bank[ch]) - 2048);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = 12'h000;
    m_result = 12'h000;
  endtask

  task automatic write_ch(input logic [2:0] addr, input logic [11:0] data);
    @(negedge clk);
    ch_wr_en = 1'b1; ch_wr_addr = addr; ch_wr_data = data;
    @(negedge clk);
    ch_wr_en = 1'b0;
    m_bank[addr] = data;
  endtask

  task automatic do_frame(input logic [5:0] cfg, input int nclk, input bit wait_done,
                          input string name, output logic [15:0] rd);
    logic [15:0] din_bits, expd;
    int vc0, waited;
    din_bits = {cfg, 10'($urandom)};
    expd = {m_result, 4'h0} >> (16 - nclk);
    vc0 = n_cfg_valid;
    rd = '0;
    @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      adc_din = din_bits[15-i];
      repeat (4) @(negedge clk);
      rd = {rd[14:0], adc_dout};
      adc_sclk = 1'b1;
      repeat (4) @(negedge clk);
      adc_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    adc_cs_n = 1'b1;
    n_vec++;
    if (rd !== expd) begin
      n_err++;
      $display("FAIL %s dout: got %h, required %h", name, rd, expd);
    end
    if (nclk >= 6) begin
      m_result = model_conv(cfg);
      waited = 0;
      while (busy !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s busy_rise: got %b, required 1", name, busy);
      end
      if (wait_done) begin
        waited = 0;
        while (busy === 1'b1 && waited < CONV + 20) begin @(negedge clk); waited++; end
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy_fall: got %b, required 0", name, busy);
        end
        n_vec++;
        if (n_cfg_valid - vc0 != 1) begin
          n_err++;
          $display("FAIL %s cfg_valid_count: got %0d, required 1", name, n_cfg_valid - vc0);
        end
        n_vec++;
        if (cfg_word !== cfg) begin
          n_err++;
          $display("FAIL %s cfg_word: got %b, required %b", name, cfg_word, cfg);
        end
      end
    end else begin
      repeat (10) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || n_cfg_valid != vc0) begin
        n_err++;
        $display("FAIL %s short_frame: got busy=%b cfg_valid_count=%0d, required busy=0 count=0",
                 name, busy, n_cfg_valid - vc0);
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    outs = {adc_dout, cfg_valid, busy, frame_err, |cfg_word};
    n_vec++;
    if (outs !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 00000", outs);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_channel();
    logic [15:0] rd;
    write_ch(3'd5, 12'hABC);
    do_frame(6'b111010, 12, 1'b1, "chan_first", rd);
    do_frame(6'($urandom), 12, 1'b1, "chan_second", rd);
    n_vec++;
    if (rd[11:0] !== 12'hABC) begin
      n_err++;
      $display("FAIL chan_value: got %h, required abc", rd[11:0]);
    end
  endtask

  task automatic test_bipolar();
    logic [15:0] rd;
    write_ch(3'd5, 12'hABC);
    do_frame(6'b111000, 12, 1'b1, "bip_first", rd);
    do_frame(6'($urandom), 12, 1'b1, "bip_second", rd);
    n_vec++;
    if (rd[11:0] !== 12'h2BC) begin
      n_err++;
      $display("FAIL bip_value: got %h, required 2bc", rd[11:0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] rd;
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) write_ch(3'($urandom), 12'($urandom));
      do_frame(6'($urandom), 12, 1'b1, "rand_frame", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    logic [4:0] outs;
    write_ch(3'd3, 12'($urandom) | 12'h401);
    do_frame(6'b101110, 12, 1'b1, "pre_reset", rd);
    do_frame(6'b101110, 12, 1'b1, "pre_reset2", rd);
    @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      adc_din = 1'b1;
      repeat (4) @(negedge clk);
      adc_sclk = 1'b1;
      repeat (4) @(negedge clk);
      adc_sclk = 1'b0;
    end
    #3 reset = 1'b1;
    #1;
    outs = {adc_dout, cfg_valid, busy, frame_err, |cfg_word};
    n_vec++;
    if (outs !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %b, required 00000", outs);
    end
    adc_cs_n = 1'b1; adc_sclk = 1'b0; adc_din = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_frame(6'($urandom), 12, 1'b1, "post_reset", rd);
    n_vec++;
    if (rd[11:0] !== 12'h000) begin
      n_err++;
      $display("FAIL post_reset_value: got %h, required 000", rd[11:0]);
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] rd;
    logic [2:0] obs;
    int waited;
    write_ch(3'($urandom), 12'($urandom));
    do_frame(6'($urandom), 12, 1'b0, "ferr_frame", rd);
    repeat (10) @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (5) @(negedge clk);
    obs = {frame_err, busy, adc_dout};
    n_vec++;
    if (obs !== 3'b110) begin
      n_err++;
      $display("FAIL ferr_set: got {err,busy,dout}=%b, required 110", obs);
    end
    adc_cs_n = 1'b1;
    waited = 0;
    while (busy === 1'b1 && waited < CONV + 20) begin @(negedge clk); waited++; end
    n_vec++;
    if (busy !== 1'b0 || frame_err !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_sticky: got busy=%b err=%b, required busy=0 err=1", busy, frame_err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++;
    if (frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_clear: got %b, required 0", frame_err);
    end
    do_frame(6'($urandom), 12, 1'b1, "ferr_after", rd);
  endtask

  task automatic test_short();
    logic [15:0] rd;
    write_ch(3'($urandom), 12'($urandom));
    do_frame(6'($urandom), 12, 1'b1, "short_setup", rd);
    do_frame(6'($urandom), 4, 1'b1, "short_frame", rd);
    do_frame(6'($urandom), 12, 1'b1, "short_after", rd);
  endtask

  task automatic test_long();
    logic [15:0] rd;
    write_ch(3'd6, 12'($urandom) | 12'h001);
    do_frame(6'b101011, 16, 1'b1, "long_frame", rd);
    do_frame(6'($urandom), 16, 1'b1, "long_read", rd);
    n_vec++;
    if (rd[3:0] !== 4'h0) begin
      n_err++;
      $display("FAIL long_tail: got %h, required 0", rd[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_channel();
    test_bipolar();
    test_random();
    test_reset_mid();
    test_frame_err();
    test_short();
    test_long();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
